// File: rtl/ac_e_unit_pkg.sv
// Shared encodings for the accumulator/E stage and the control logic that
// drives it: skip-condition selects, flag reset values and ALU selects.
package ac_e_unit_pkg;

  // Register-reference skip condition selects (skip_sel).
  localparam logic [1:0] SKIP_SPA = 2'd0;  // skip if AC positive (MSB clear)
  localparam logic [1:0] SKIP_SNA = 2'd1;  // skip if AC negative (MSB set)
  localparam logic [1:0] SKIP_SZA = 2'd2;  // skip if AC is zero
  localparam logic [1:0] SKIP_SZE = 2'd3;  // skip if E is zero

  // Status flags carried alongside AC.
  typedef struct packed {
    logic n;  // negative
    logic z;  // zero
    logic c;  // carry
    logic v;  // signed overflow
  } flags_t;

  // Flag reset values: AC resets to zero, so Z starts set.
  localparam logic FLAG_N_RST = 1'b0;
  localparam logic FLAG_Z_RST = 1'b1;
  localparam logic FLAG_C_RST = 1'b0;
  localparam logic FLAG_V_RST = 1'b0;

  localparam flags_t FLAGS_RST = '{
    n: FLAG_N_RST,
    z: FLAG_Z_RST,
    c: FLAG_C_RST,
    v: FLAG_V_RST
  };

  // Flags after CLA: the same as after reset.
  localparam flags_t FLAGS_CLR = FLAGS_RST;

  // ALU operation selects, shared so the control unit and the datapath
  // agree on which operations also load E from the ALU carry.
  typedef enum logic [2:0] {
    ALU_AND    = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_LDA    = 3'd2,
    ALU_CMA    = 3'd3,
    ALU_CIR    = 3'd4,
    ALU_CIL    = 3'd5,
    ALU_PASS_B = 3'd6,
    ALU_NOP    = 3'd7
  } alu_sel_e;

  // True for ALU operations whose carry out is architecturally captured in E.
  function automatic logic alu_sel_writes_e(input alu_sel_e sel);
    return (sel == ALU_ADD) || (sel == ALU_CIR) || (sel == ALU_CIL);
  endfunction

endpackage

// File: rtl/ac_e_unit_incrementer.sv
// Combinational +1 for a WORD-wide register. Reports the unsigned wrap
// carry (all-ones -> zero) and the signed overflow (max positive -> min
// negative). Used for AC INC and intended for PC/AR increment as well.
module ac_incrementer
  import ac_e_unit_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic [WORD-1:0] a_i,
  output logic [WORD-1:0] sum_o,
  output logic            carry_o,
  output logic            ovf_o
);

  // Add one with an extra bit to catch the wrap; overflow is the only
  // increment case where the sign bit goes from 0 to 1.
  always_comb begin
    {carry_o, sum_o} = {1'b0, a_i} + {{WORD{1'b0}}, 1'b1};
    ovf_o            = ~a_i[WORD-1] & sum_o[WORD-1];
  end

endmodule

// File: rtl/ac_e_unit.sv
// Accumulator / E / status-flag stage sitting directly after the ALU.
// Captures ALU results on command, performs CLA/INC/CLE/CME locally and
// evaluates the SPA/SNA/SZA/SZE skip conditions for the control unit.
//
// There is no handshake: each command input is a one-cycle strobe acted on
// at the next rising edge. skip is a registered one-cycle pulse reporting
// the condition selected by skip_sel, evaluated on the AC/E values held
// before that same edge (so a simultaneous write does not affect it).
// Every output is a register; no input reaches an output combinationally.
module ac_e_unit
  import ac_e_unit_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] alu_out,
  input  logic            alu_co,
  input  logic            alu_ovf,
  input  logic            alu_n,
  input  logic            alu_z,
  input  logic            ac_ld,
  input  logic            ac_clr,
  input  logic            ac_inc,
  input  logic            e_ld,
  input  logic            e_clr,
  input  logic            e_cmp,
  input  logic            skip_en,
  input  logic [1:0]      skip_sel,
  output logic [WORD-1:0] ac,
  output logic            e,
  output logic            flag_n,
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_v,
  output logic            skip
);

  // Architectural state and next-state.
  logic [WORD-1:0] ac_q, ac_d;
  logic            e_q, e_d;
  flags_t          flags_q, flags_d;
  logic            skip_q, skip_d;

  // Incrementer results for the current AC.
  logic [WORD-1:0] inc_sum;
  logic            inc_carry;
  logic            inc_ovf;

  // Selected skip condition on the current (pre-update) AC/E.
  logic            skip_cond;

  ac_incrementer #(
    .WORD (WORD)
  ) u_inc (
    .a_i     (ac_q),
    .sum_o   (inc_sum),
    .carry_o (inc_carry),
    .ovf_o   (inc_ovf)
  );

  // Evaluate the selected skip condition from registered AC/E only.
  always_comb begin
    skip_cond = 1'b0;
    case (skip_sel)
      SKIP_SPA: skip_cond = ~ac_q[WORD-1];
      SKIP_SNA: skip_cond =  ac_q[WORD-1];
      SKIP_SZA: skip_cond = (ac_q == '0);
      SKIP_SZE: skip_cond = ~e_q;
      default:  skip_cond = 1'b0;
    endcase
  end

  // AC and flags next-state: CLA beats load beats INC; otherwise hold.
  always_comb begin
    ac_d    = ac_q;
    flags_d = flags_q;
    if (ac_clr) begin
      ac_d    = '0;
      flags_d = FLAGS_CLR;
    end else if (ac_ld) begin
      ac_d      = alu_out;
      flags_d.n = alu_n;
      flags_d.z = alu_z;
      flags_d.c = alu_co;
      flags_d.v = alu_ovf;
    end else if (ac_inc) begin
      ac_d      = inc_sum;
      flags_d.n = inc_sum[WORD-1];
      flags_d.z = (inc_sum == '0);
      flags_d.c = inc_carry;
      flags_d.v = inc_ovf;
    end
  end

  // E next-state: CLE beats CME beats load from ALU carry; otherwise hold.
  always_comb begin
    e_d = e_q;
    if (e_clr) begin
      e_d = 1'b0;
    end else if (e_cmp) begin
      e_d = ~e_q;
    end else if (e_ld) begin
      e_d = alu_co;
    end
  end

  // Skip request is only raised in the cycle after skip_en.
  always_comb begin
    skip_d = skip_en & skip_cond;
  end

  // State registers; reset overrides every command and drops a pending skip.
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q    <= '0;
      e_q     <= 1'b0;
      flags_q <= FLAGS_RST;
      skip_q  <= 1'b0;
    end else begin
      ac_q    <= ac_d;
      e_q     <= e_d;
      flags_q <= flags_d;
      skip_q  <= skip_d;
    end
  end

  assign ac     = ac_q;
  assign e      = e_q;
  assign flag_n = flags_q.n;
  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;
  assign skip   = skip_q;

endmodule

// File: tb/tb_ac_e_unit.sv
// Bench for ac_e_unit: directed cases followed by random commands, checked
// against an arithmetic reference model through an expected-value queue.
module tb_ac_e_unit;

  localparam int WORD = 16;
  localparam int W    = WORD + 6;  // {ac, e, n, z, c, v, skip}
  localparam longint MOD  = 64'd1 << WORD;
  localparam longint HALF = MOD / 2;

  typedef struct packed {
    logic            rst;
    logic            ald;
    logic            aclr;
    logic            ainc;
    logic            eld;
    logic            eclr;
    logic            ecmp;
    logic            sen;
    logic [1:0]      sel;
    logic [WORD-1:0] aout;
    logic            co;
    logic            ovf;
    logic            n;
    logic            z;
  } stim_t;

  // ---------------- clock / reset / DUT ----------------
  logic            clk;
  logic            rst;
  logic [WORD-1:0] alu_out;
  logic            alu_co, alu_ovf, alu_n, alu_z;
  logic            ac_ld, ac_clr, ac_inc;
  logic            e_ld, e_clr, e_cmp;
  logic            skip_en;
  logic [1:0]      skip_sel;
  logic [WORD-1:0] ac;
  logic            e, flag_n, flag_z, flag_c, flag_v, skip;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ac_e_unit #(.WORD(WORD)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_out  (alu_out),
    .alu_co   (alu_co),
    .alu_ovf  (alu_ovf),
    .alu_n    (alu_n),
    .alu_z    (alu_z),
    .ac_ld    (ac_ld),
    .ac_clr   (ac_clr),
    .ac_inc   (ac_inc),
    .e_ld     (e_ld),
    .e_clr    (e_clr),
    .e_cmp    (e_cmp),
    .skip_en  (skip_en),
    .skip_sel (skip_sel),
    .ac       (ac),
    .e        (e),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .skip     (skip)
  );

  // ---------------- reference model ----------------
  int   checks = 0;
  int   passes = 0;
  logic [W-1:0] exp_q[$];

  longint m_ac   = 0;
  logic   m_e    = 1'b0;
  logic   m_n    = 1'b0;
  logic   m_z    = 1'b1;
  logic   m_c    = 1'b0;
  logic   m_v    = 1'b0;
  logic   m_skip = 1'b0;

  task automatic model(input stim_t s);
    longint old_ac;
    logic   old_e;
    old_ac = m_ac;
    old_e  = m_e;
    if (s.rst) begin
      m_ac = 0; m_e = 0; m_n = 0; m_z = 1; m_c = 0; m_v = 0; m_skip = 0;
    end else begin
      if (!s.sen)          m_skip = 1'b0;
      else if (s.sel == 0) m_skip = (old_ac < HALF);
      else if (s.sel == 1) m_skip = (old_ac >= HALF);
      else if (s.sel == 2) m_skip = (old_ac == 0);
      else                 m_skip = (old_e == 1'b0);

      if (s.aclr) begin
        m_ac = 0; m_n = 0; m_z = 1; m_c = 0; m_v = 0;
      end else if (s.ald) begin
        m_ac = longint'(s.aout);
        m_n = s.n; m_z = s.z; m_c = s.co; m_v = s.ovf;
      end else if (s.ainc) begin
        m_ac = (old_ac + 1) % MOD;
        m_c  = (old_ac == MOD - 1);
        m_v  = (old_ac == HALF - 1);
        m_n  = (m_ac >= HALF);
        m_z  = (m_ac == 0);
      end

      if (s.eclr)      m_e = 1'b0;
      else if (s.ecmp) m_e = ~old_e;
      else if (s.eld)  m_e = s.co;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input stim_t s);
    logic [WORD-1:0] exp_ac;
    @(negedge clk);
    rst      = s.rst;
    ac_ld    = s.ald;
    ac_clr   = s.aclr;
    ac_inc   = s.ainc;
    e_ld     = s.eld;
    e_clr    = s.eclr;
    e_cmp    = s.ecmp;
    skip_en  = s.sen;
    skip_sel = s.sel;
    alu_out  = s.aout;
    alu_co   = s.co;
    alu_ovf  = s.ovf;
    alu_n    = s.n;
    alu_z    = s.z;
    model(s);
    exp_ac = m_ac[WORD-1:0];
    exp_q.push_back({exp_ac, m_e, m_n, m_z, m_c, m_v, m_skip});
  endtask

  function automatic stim_t load(input logic [WORD-1:0] v, input logic co,
                                 input logic eld);
    stim_t s;
    s      = '0;
    s.ald  = 1'b1;
    s.aout = v;
    s.co   = co;
    s.eld  = eld;
    s.n    = v[WORD-1];
    s.z    = (v == '0);
    return s;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [WORD-1:0] act,
                       input logic [WORD-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    logic [W-1:0] x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("ac",    ac, x[W-1:6]);
      check("e",     {{(WORD-1){1'b0}}, e}, {{(WORD-1){1'b0}}, x[5]});
      check("flags", {{(WORD-4){1'b0}}, flag_n, flag_z, flag_c, flag_v},
                     {{(WORD-4){1'b0}}, x[4:1]});
      check("skip",  {{(WORD-1){1'b0}}, skip}, {{(WORD-1){1'b0}}, x[0]});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    rst = 1'b1; ac_ld = 0; ac_clr = 0; ac_inc = 0; e_ld = 0; e_clr = 0;
    e_cmp = 0; skip_en = 0; skip_sel = 0; alu_out = '0; alu_co = 0;
    alu_ovf = 0; alu_n = 0; alu_z = 0;

    // reset state
    s = '0; s.rst = 1'b1;
    step(s); step(s);
    s = '0; step(s);

    // ADD-style load of AC and E together
    step(load(16'h1234, 1'b1, 1'b1));
    s = '0; step(s);

    // INC wrap from all-ones, E untouched
    step(load(16'hFFFF, 1'b1, 1'b1));
    s = '0; s.ainc = 1'b1; step(s);
    // INC across signed boundary
    step(load(16'h7FFF, 1'b0, 1'b0));
    s = '0; s.ainc = 1'b1; step(s);

    // AC command priority, E command priority
    s = '0; s.aclr = 1; s.ald = 1; s.ainc = 1; s.aout = 16'h00AA; step(s);
    s = '0; s.eclr = 1; s.ecmp = 1; step(s);     // e was 1 -> 0
    s = '0; s.ecmp = 1; step(s);                 // e 0 -> 1

    // skip conditions
    s = '0; s.sen = 1; s.sel = 2'd2; step(s);    // SZA, ac=0 -> 1
    s = '0; step(s);                             // pulse ends
    step(load(16'h8001, 1'b0, 1'b1));            // e <= 0
    s = '0; s.sen = 1; s.sel = 2'd0; step(s);    // SPA -> 0
    s = '0; s.sen = 1; s.sel = 2'd1; step(s);    // SNA -> 1
    s = '0; s.sen = 1; s.sel = 2'd3; step(s);    // SZE -> 1

    // skip uses pre-update AC
    s = '0; s.aclr = 1; step(s);
    s = load(16'h0005, 1'b0, 1'b0); s.sen = 1; s.sel = 2'd2; step(s);
    s = '0; step(s);

    // reset beats INC and pending skip
    step(load(16'h00FF, 1'b0, 1'b0));
    s = '0; s.rst = 1; s.ainc = 1; s.sen = 1; s.sel = 2'd0; step(s);
    s = '0; step(s);

    // random commands
    for (int i = 0; i < 3000; i++) begin
      s      = '0;
      s.rst  = ($urandom_range(0, 63) == 0);
      s.aclr = ($urandom_range(0, 7) == 0);
      s.ald  = ($urandom_range(0, 2) == 0);
      s.ainc = ($urandom_range(0, 2) == 0);
      s.eld  = ($urandom_range(0, 3) == 0);
      s.eclr = ($urandom_range(0, 5) == 0);
      s.ecmp = ($urandom_range(0, 3) == 0);
      s.sen  = ($urandom_range(0, 1) == 0);
      s.sel  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       s.aout = 16'hFFFF;
        1:       s.aout = 16'h7FFF;
        2:       s.aout = 16'h0000;
        3:       s.aout = 16'hFFFE;
        default: s.aout = 16'($urandom);
      endcase
      s.co  = 1'($urandom_range(0, 1));
      s.ovf = 1'($urandom_range(0, 1));
      s.n   = 1'($urandom_range(0, 1));
      s.z   = 1'($urandom_range(0, 1));
      step(s);
    end

    s = '0; step(s); step(s);

    // drain with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
